// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op codes and issue FSM encoding for the E-stage multiply/divide path
package mdu_pkg;
  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;
  localparam logic [2:0] MD_MADD  = 3'd7;
  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MFHI  = 4'd8;
  localparam logic [3:0] OP_MFLO  = 4'd9;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;
endpackage

// File: rtl/mdu_issue.sv
// mdu_issue: issues MD-class ops to the multiply/divide unit and stalls the pipe
// until HI/LO are safe to read.
module mdu_issue
  import mdu_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req,
  input  logic [3:0]  ReqOp,
  input  logic [31:0] RsData,
  input  logic [31:0] RtData,
  input  logic        Flush,
  input  logic        MduBusy,
  input  logic [31:0] MduHI,
  input  logic [31:0] MduLO,
  output logic [2:0]  MDOp,
  output logic [31:0] MData1,
  output logic [31:0] MData2,
  output logic        Stall,
  output logic [31:0] RdData,
  output logic        RdValid,
  output logic [15:0] StallCycles
);
  state_e      state_q, state_d;
  logic [2:0]  mdop_q, mdop_d;
  logic [31:0] data1_q, data1_d, data2_q, data2_d, rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        valid, accept, is_md, is_rd;
  always_comb begin
    valid       = Req && !Flush && ReqOp >= OP_MULT && ReqOp <= OP_MFLO;
    Stall       = valid && (state_q == S_ISSUE || (state_q == S_WAIT && MduBusy));
    accept      = valid && !Stall;
    is_md       = accept && ReqOp <= OP_MADD;
    is_rd       = accept && ReqOp >= OP_MFHI;
    // mdop_q still holds the issued op during ISSUE, so it decides WAIT vs IDLE
    state_d     = is_md ? S_ISSUE :
                  state_q == S_ISSUE ? ((mdop_q == MD_MTHI || mdop_q == MD_MTLO) ? S_IDLE : S_WAIT) :
                  (state_q == S_WAIT && !MduBusy) ? S_IDLE : state_q;
    mdop_d      = is_md ? ReqOp[2:0] : MD_NONE;
    data1_d     = is_md ? RsData : data1_q;
    data2_d     = is_md ? RtData : data2_q;
    rd_data_d   = is_rd ? (ReqOp == OP_MFHI ? MduHI : MduLO) : rd_data_q;
    rd_valid_d  = is_rd;
    stall_cnt_d = (Stall && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      mdop_q      <= MD_NONE;
      data1_q     <= '0;
      data2_q     <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mdop_q      <= mdop_d;
      data1_q     <= data1_d;
      data2_q     <= data2_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
  assign MDOp        = mdop_q;
  assign MData1      = data1_q;
  assign MData2      = data2_q;
  assign RdData      = rd_data_q;
  assign RdValid     = rd_valid_q;
  assign StallCycles = stall_cnt_q;
endmodule

// File: tb/tb_mdu_issue.sv
// tb_mdu_issue: directed vector table plus a long stall run for counter saturation
module tb_mdu_issue;
  logic        clk = 1'b0;
  logic        rst, req, flush, busy;
  logic [3:0]  op;
  logic [31:0] rs, rt, hi, lo;
  logic [2:0]  mdop;
  logic [31:0] d1, d2, rdd;
  logic        stall, rdv;
  logic [15:0] cnt;
  int          checks = 0;
  int          errors = 0;
  int          idx;

  always #5 clk = ~clk;

  mdu_issue dut (
    .Clk(clk), .Reset(rst), .Req(req), .ReqOp(op), .RsData(rs), .RtData(rt),
    .Flush(flush), .MduBusy(busy), .MduHI(hi), .MduLO(lo),
    .MDOp(mdop), .MData1(d1), .MData2(d2), .Stall(stall),
    .RdData(rdd), .RdValid(rdv), .StallCycles(cnt)
  );

  typedef struct {
    logic        rst, req;
    logic [3:0]  op;
    logic [31:0] rs, rt;
    logic        flush, busy;
    logic [31:0] hi, lo;
    logic        stall;
    logic [2:0]  mdop;
    logic [31:0] d1, d2;
    logic        rdv;
    logic [31:0] rdd;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[33];

  function automatic vec_t v(logic r, logic q, logic [3:0] o, logic [31:0] a, logic [31:0] b,
                             logic f, logic bz, logic [31:0] h, logic [31:0] l,
                             logic es, logic [2:0] em, logic [31:0] e1, logic [31:0] e2,
                             logic ev, logic [31:0] ed, logic [15:0] ec);
    vec_t t;
    t.rst = r; t.req = q; t.op = o; t.rs = a; t.rt = b; t.flush = f; t.busy = bz;
    t.hi = h; t.lo = l; t.stall = es; t.mdop = em; t.d1 = e1; t.d2 = e2;
    t.rdv = ev; t.rdd = ed; t.cnt = ec;
    return t;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h want %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(logic r, logic q, logic [3:0] o, logic [31:0] a, logic [31:0] b,
                       logic f, logic bz, logic [31:0] h, logic [31:0] l);
    rst = r; req = q; op = o; rs = a; rt = b; flush = f; busy = bz; hi = h; lo = l;
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    //          rst req op  rs      rt          fl bz hi          lo          | st mdop d1      d2          rdv rdd         cnt
    vecs[0]  = v(1, 0, 0, 0,      0,          0, 0, 0,          0,          0, 0, 0,      0,          0, 0,          0);
    vecs[1]  = v(0, 1, 1, 3,      32'hFFFFFFFE, 0, 0, 0,        0,          0, 1, 3,      32'hFFFFFFFE, 0, 0,        0);
    vecs[2]  = v(0, 1, 9, 0,      0,          0, 0, 0,          0,          1, 0, 3,      32'hFFFFFFFE, 0, 0,        1);
    vecs[3]  = v(0, 1, 9, 0,      0,          0, 1, 0,          0,          1, 0, 3,      32'hFFFFFFFE, 0, 0,        2);
    vecs[4]  = v(0, 1, 9, 0,      0,          0, 1, 0,          0,          1, 0, 3,      32'hFFFFFFFE, 0, 0,        3);
    vecs[5]  = v(0, 1, 9, 0,      0,          0, 0, 32'hFFFFFFFF, 32'hFFFFFFFA, 0, 0, 3,  32'hFFFFFFFE, 1, 32'hFFFFFFFA, 3);
    vecs[6]  = v(0, 0, 0, 0,      0,          0, 0, 0,          0,          0, 0, 3,      32'hFFFFFFFE, 0, 32'hFFFFFFFA, 3);
    vecs[7]  = v(0, 1, 5, 32'h1234, 0,        0, 0, 0,          0,          0, 5, 32'h1234, 0,        0, 32'hFFFFFFFA, 3);
    vecs[8]  = v(0, 1, 8, 0,      0,          0, 0, 0,          0,          1, 0, 32'h1234, 0,        0, 32'hFFFFFFFA, 4);
    vecs[9]  = v(0, 1, 8, 0,      0,          0, 0, 32'h1234,   0,          0, 0, 32'h1234, 0,        1, 32'h1234,   4);
    vecs[10] = v(0, 1, 3, 7,      0,          0, 0, 32'h1234,   0,          0, 3, 7,      0,          0, 32'h1234,   4);
    vecs[11] = v(0, 0, 0, 0,      0,          0, 0, 32'h1234,   0,          0, 0, 7,      0,          0, 32'h1234,   4);
    vecs[12] = v(0, 1, 9, 0,      0,          0, 0, 32'h1234,   5,          0, 0, 7,      0,          1, 5,          4);
    vecs[13] = v(0, 1, 8, 0,      0,          0, 1, 32'h1234,   5,          0, 0, 7,      0,          1, 32'h1234,   4);
    vecs[14] = v(0, 1, 1, 9,      9,          1, 0, 32'h1234,   5,          0, 0, 7,      0,          0, 32'h1234,   4);
    vecs[15] = v(0, 1, 1, 1,      2,          0, 0, 0,          0,          0, 1, 1,      2,          0, 32'h1234,   4);
    vecs[16] = v(0, 1, 9, 0,      0,          1, 0, 0,          0,          0, 0, 1,      2,          0, 32'h1234,   4);
    vecs[17] = v(0, 1, 8, 0,      0,          0, 1, 0,          0,          1, 0, 1,      2,          0, 32'h1234,   5);
    vecs[18] = v(1, 1, 1, 0,      0,          0, 1, 0,          0,          1, 0, 0,      0,          0, 0,          0);
    vecs[19] = v(0, 1, 1, 4,      5,          0, 1, 0,          0,          0, 1, 4,      5,          0, 0,          0);
    vecs[20] = v(0, 0, 0, 0,      0,          0, 0, 0,          0,          0, 0, 4,      5,          0, 0,          0);
    vecs[21] = v(1, 1, 1, 8,      8,          0, 0, 0,          0,          0, 0, 0,      0,          0, 0,          0);
    vecs[22] = v(0, 1, 1, 2,      3,          0, 0, 0,          0,          0, 1, 2,      3,          0, 0,          0);
    vecs[23] = v(0, 0, 0, 0,      0,          0, 0, 0,          0,          0, 0, 2,      3,          0, 0,          0);
    vecs[24] = v(0, 1, 4, 6,      7,          0, 0, 0,          0,          0, 4, 6,      7,          0, 0,          0);
    vecs[25] = v(0, 1, 8, 0,      0,          0, 0, 0,          0,          1, 0, 6,      7,          0, 0,          1);
    vecs[26] = v(0, 1, 12, 0,     0,          0, 1, 0,          0,          0, 0, 6,      7,          0, 0,          1);
    vecs[27] = v(0, 1, 0, 0,      0,          0, 1, 0,          0,          0, 0, 6,      7,          0, 0,          1);
    vecs[28] = v(0, 1, 7, 32'hA,  32'hB,      0, 0, 0,          0,          0, 7, 32'hA,  32'hB,      0, 0,          1);
    vecs[29] = v(0, 1, 6, 0,      0,          0, 0, 0,          0,          1, 0, 32'hA,  32'hB,      0, 0,          2);
    vecs[30] = v(0, 1, 6, 32'hC,  32'hD,      0, 0, 0,          0,          0, 6, 32'hC,  32'hD,      0, 0,          2);
    vecs[31] = v(0, 0, 0, 0,      0,          0, 0, 0,          0,          0, 0, 32'hC,  32'hD,      0, 0,          2);
    vecs[32] = v(0, 1, 9, 0,      0,          0, 1, 0,          32'h77,     0, 0, 32'hC,  32'hD,      1, 32'h77,     2);

    for (int i = 0; i < 33; i++) begin
      idx = i;
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].req, vecs[i].op, vecs[i].rs, vecs[i].rt,
            vecs[i].flush, vecs[i].busy, vecs[i].hi, vecs[i].lo);
      #1;
      chk("stall", 32'(stall), 32'(vecs[i].stall));
      @(posedge clk);
      #1;
      chk("mdop",  32'(mdop), 32'(vecs[i].mdop));
      chk("data1", d1, vecs[i].d1);
      chk("data2", d2, vecs[i].d2);
      chk("rdvalid", 32'(rdv), 32'(vecs[i].rdv));
      chk("rddata", rdd, vecs[i].rdd);
      chk("stallcnt", 32'(cnt), 32'(vecs[i].cnt));
    end

    idx = 100;
    @(negedge clk); drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); drive(0, 1, 1, 1, 1, 0, 0, 0, 0);
    @(negedge clk); drive(0, 1, 9, 0, 0, 0, 1, 0, 0);
    for (int n = 0; n < 100; n++) @(negedge clk);
    chk("sat_early", 32'(cnt), 32'd100);
    for (int n = 100; n < 70000; n++) @(negedge clk);
    chk("sat_stall", 32'(stall), 32'd1);
    chk("sat_cnt", 32'(cnt), 32'hFFFF);
    for (int n = 0; n < 5; n++) @(negedge clk);
    chk("sat_hold", 32'(cnt), 32'hFFFF);
    busy = 1'b0;
    #1;
    chk("sat_release", 32'(stall), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
